// File: rtl/video_timing_packer.sv
// HDMI-style H/V timing generator: pulls RGB888 pixels during active video and emits the 50-bit pack bus.
// Build option VTP_TEST_PATTERN_EN: underflow pixels show 8 vertical colour bars instead of black.
module video_timing_packer #(
    parameter int unsigned H_ACT  = 1280,
    parameter int unsigned V_ACT  = 720,
    parameter int unsigned H_SYNC = 40,
    parameter int unsigned H_BP   = 220,
    parameter int unsigned H_FP   = 110,
    parameter int unsigned V_SYNC = 5,
    parameter int unsigned V_BP   = 20,
    parameter int unsigned V_FP   = 5,
    parameter bit          HS_POL = 1'b1,
    parameter bit          VS_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        i_valid,
    input  logic [7:0]  i_r,
    input  logic [7:0]  i_g,
    input  logic [7:0]  i_b,
    output logic        o_ready,
    output logic [49:0] o_pack,
    output logic        o_frame_start,
    output logic        o_underflow
);
    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int unsigned H_ACT0  = H_SYNC + H_BP;
    localparam int unsigned V_ACT0  = V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned XW      = $clog2(H_ACT);
    localparam int unsigned YW      = $clog2(V_ACT);
    localparam int unsigned PX_W    = 11;
    localparam int unsigned PY_W    = 10;

    // Pack bus payload below the clock bit; x/y are zero-extended into fixed fields.
    typedef struct packed {
        logic            href;
        logic            hsync;
        logic            vsync;
        logic            de;
        logic [7:0]      r;
        logic [7:0]      g;
        logic [7:0]      b;
        logic [PX_W-1:0] x;
        logic [PY_W-1:0] y;
    } pack_t;

    localparam pack_t BLANK = '{href: 1'b0, hsync: ~HS_POL, vsync: ~VS_POL, de: 1'b0,
                                r: 8'h00, g: 8'h00, b: 8'h00, x: '0, y: '0};

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    pack_t         pack_q, pack_d;
    logic          fs_q, fs_d;
    logic          uf_q, uf_d;

    logic          h_last_c, v_last_c, h_act_c, v_act_c, de_c, run_c, ready_c;
    logic [XW-1:0] x_c;
    logic [YW-1:0] y_c;
    logic [23:0]   fill_c;

    // Position decode from the live counters.
    assign h_last_c = (32'(h_q) == H_TOTAL - 1);
    assign v_last_c = (32'(v_q) == V_TOTAL - 1);
    assign h_act_c  = (32'(h_q) >= H_ACT0) && (32'(h_q) < H_ACT0 + H_ACT);
    assign v_act_c  = (32'(v_q) >= V_ACT0) && (32'(v_q) < V_ACT0 + V_ACT);
    assign de_c     = h_act_c && v_act_c;
    assign x_c      = de_c ? XW'(32'(h_q) - H_ACT0) : '0;
    assign y_c      = de_c ? YW'(32'(v_q) - V_ACT0) : '0;

    // IDLE with en already high starts the frame this cycle, so frame_start lands one clock after en.
    assign run_c    = (state_q != IDLE) || en;
    assign ready_c  = run_c && de_c;

`ifdef VTP_TEST_PATTERN_EN
    logic [2:0] bar_c;
    assign bar_c  = x_c[XW-1 -: 3];
    assign fill_c = {{8{~bar_c[1]}}, {8{~bar_c[2]}}, {8{~bar_c[0]}}};
`else
    assign fill_c = 24'h000000;
`endif

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        pack_d  = BLANK;
        fs_d    = 1'b0;
        uf_d    = uf_q;

        case (state_q)
            IDLE:     if (en) state_d = RUN;
            RUN:      if (!en) state_d = (h_last_c && v_last_c) ? IDLE : STOPPING;
            STOPPING: begin
                if (en)                       state_d = RUN;
                else if (h_last_c && v_last_c) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase

        if (run_c) begin
            if (h_last_c) begin
                h_d = '0;
                v_d = v_last_c ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end

            pack_d.hsync = (32'(h_q) < H_SYNC) ? HS_POL : ~HS_POL;
            pack_d.vsync = (32'(v_q) < V_SYNC) ? VS_POL : ~VS_POL;
            pack_d.de    = de_c;
            pack_d.href  = de_c;
            pack_d.x     = PX_W'(x_c);
            pack_d.y     = PY_W'(y_c);
            if (ready_c) begin
                {pack_d.r, pack_d.g, pack_d.b} = i_valid ? {i_r, i_g, i_b} : fill_c;
                if (!i_valid) uf_d = 1'b1;
            end
            fs_d = (h_q == '0) && (v_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            pack_q  <= BLANK;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            pack_q  <= pack_d;
            fs_q    <= fs_d;
            uf_q    <= uf_d;
        end
    end

    assign o_ready       = ready_c;
    assign o_pack        = {clk, pack_q};
    assign o_frame_start = fs_q;
    assign o_underflow   = uf_q;

endmodule

// File: tb/tb_video_timing_packer.sv
// Bench for video_timing_packer: a frame-position reference model queues the expected output of
// every clock, and a separate monitor pops and compares one entry per clock.
module tb_video_timing_packer;
    localparam int unsigned H_ACT  = 8;
    localparam int unsigned V_ACT  = 4;
    localparam int unsigned H_SYNC = 2;
    localparam int unsigned H_BP   = 2;
    localparam int unsigned H_FP   = 2;
    localparam int unsigned V_SYNC = 1;
    localparam int unsigned V_BP   = 1;
    localparam int unsigned V_FP   = 1;
    localparam bit          HS_POL = 1'b1;
    localparam bit          VS_POL = 1'b1;
    localparam int          H_TOT  = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int          V_TOT  = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int          FRAME  = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        rstn, en, i_valid;
    logic [7:0]  i_r, i_g, i_b;
    logic        o_ready, o_frame_start, o_underflow;
    logic [49:0] o_pack;

    typedef struct packed {
        logic [48:0] pack;
        logic        fs;
        logic        uf;
        logic        ready;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_pos;
    bit          m_active;
    bit          m_uf;
    logic [23:0] next_pix;

`ifdef VTP_TEST_PATTERN_EN
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

    video_timing_packer #(
        .H_ACT(H_ACT), .V_ACT(V_ACT), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_FP(V_FP), .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .i_valid(i_valid),
        .i_r(i_r), .i_g(i_g), .i_b(i_b), .o_ready(o_ready), .o_pack(o_pack),
        .o_frame_start(o_frame_start), .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    function automatic bit pos_de(input int pos);
        int h = pos % H_TOT;
        int v = pos / H_TOT;
        return (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACT) &&
               (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACT);
    endfunction

    function automatic logic [23:0] fill(input int x);
`ifdef VTP_TEST_PATTERN_EN
        return bars[(x * 8) / H_ACT];
`else
        return (x < 0) ? 24'hxxxxxx : 24'h000000;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual %h required %h", name, $time, act, req);
        end
    endtask

    // Reference model for one clock: frame position 0..FRAME-1 with h = pos%H_TOT, v = pos/H_TOT.
    task automatic step(input bit r, input bit e, input bit v);
        exp_t        ex;
        int          h, vl, x, y;
        bit          de, hs, vs;
        logic [23:0] pix;
        ex.pack = {1'b0, !HS_POL, !VS_POL, 1'b0, 24'h0, 11'd0, 10'd0};
        ex.fs   = 1'b0;
        if (!r) begin
            m_active = 0;
            m_pos    = 0;
            m_uf     = 0;
        end else if (m_active || e) begin
            h   = m_pos % H_TOT;
            vl  = m_pos / H_TOT;
            de  = pos_de(m_pos);
            hs  = (h < H_SYNC) ? HS_POL : !HS_POL;
            vs  = (vl < V_SYNC) ? VS_POL : !VS_POL;
            x   = de ? h - (H_SYNC + H_BP) : 0;
            y   = de ? vl - (V_SYNC + V_BP) : 0;
            pix = !de ? 24'h0 : (v ? next_pix : fill(x));
            if (de && !v) m_uf = 1;
            if (de && v) next_pix = next_pix + 24'd1;
            ex.pack  = {de, hs, vs, de, pix, 11'(x), 10'(y)};
            ex.fs    = (m_pos == 0);
            m_active = !(!e && m_pos == FRAME - 1);
            m_pos    = (m_pos + 1) % FRAME;
        end
        ex.uf    = m_uf;
        ex.ready = r && (m_active || e) && pos_de(m_pos);
        exp_q.push_back(ex);
    endtask

    task automatic cyc(input bit r, input bit e, input bit v);
        @(negedge clk);
        rstn    = r;
        en      = e;
        i_valid = v;
        {i_r, i_g, i_b} = next_pix;
        step(r, e, v);
    endtask

    // Monitor: one expected entry per clock, sampled just after the active edge.
    initial begin
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                chk("pack", 64'(o_pack[48:0]), 64'(ex.pack));
                chk("frame_start", 64'(o_frame_start), 64'(ex.fs));
                chk("underflow", 64'(o_underflow), 64'(ex.uf));
                chk("ready", 64'(o_ready), 64'(ex.ready));
            end
        end
    end

    initial begin
        bit en_r;
        rstn     = 1'b0;
        en       = 1'b0;
        i_valid  = 1'b0;
        {i_r, i_g, i_b} = 24'h0;
        next_pix = 24'h000001;
        m_pos    = 0;
        m_active = 0;
        m_uf     = 0;

        repeat (3) cyc(0, 0, 0);
        repeat (2) cyc(1, 0, 1);
        // Two clean frames with incrementing pixels.
        repeat (2 * FRAME) cyc(1, 1, 1);
        // One dropped pixel at x=3, y=1.
        for (int i = 0; i < FRAME; i++)
            cyc(1, 1, m_pos != (V_SYNC + V_BP + 1) * H_TOT + H_SYNC + H_BP + 3);
        repeat (FRAME) cyc(1, 1, 1);
        // Drop en at v=3, let the frame finish into IDLE, then restart.
        for (int i = 0; i < 2 * FRAME && m_pos != 3 * H_TOT; i++) cyc(1, 1, 1);
        repeat (FRAME + 10) cyc(1, 0, 1);
        repeat (FRAME + 20) cyc(1, 1, 1);
        // Reset in the middle of an active line with en held high.
        for (int i = 0; i < 2 * FRAME && m_pos != 4 * H_TOT + 6; i++) cyc(1, 1, 1);
        repeat (2) cyc(0, 1, 1);
        repeat (FRAME + 12) cyc(1, 1, 1);
        // Whole frame without valid pixels.
        for (int i = 0; i < 2 * FRAME && m_pos != 0; i++) cyc(1, 1, 1);
        repeat (FRAME) cyc(1, 1, 0);
        // Randomised en bursts, valid gaps and occasional resets.
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) en_r = !en_r;
            cyc($urandom_range(0, 599) != 0, en_r, $urandom_range(0, 7) != 0);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_packer.md
Name: video_timing_packer

Overview:
- Source end of the 50-bit pixel pack bus; the white-balance and other pack-to-pack stages consume what this block produces.
- Free-running H/V counters generate HDMI-style timing: hsync, vsync, de, href and active x/y.
- Pulls RGB888 pixels from an upstream buffer (frame-buffer reader or FIFO) via valid/ready during active video.
- Emits everything through hdmi_pack onto o_pack.

Parameters:
- H_ACT, 1280: active pixels per line
- V_ACT, 720: active lines per frame
- H_SYNC, 40 / H_BP, 220 / H_FP, 110: horizontal sync, back porch and front porch widths in clocks
- V_SYNC, 5 / V_BP, 20 / V_FP, 5: vertical sync, back porch and front porch widths in lines
- HS_POL, 1 / VS_POL, 1: active level of hsync/vsync

Ports:
- clk  in  1  pixel clock; also carried in o_pack
- rstn  in  1  synchronous reset, active-low
- en  in  1  run enable
- i_valid  in  1  upstream pixel valid
- i_r / i_g / i_b  in  8 each  upstream pixel
- o_ready  out  1  pixel request; combinational from counters
- o_pack  out  50  packed stream (clk, href, hsync, vsync, de, r, g, b, x[$clog2(H_ACT)], y[$clog2(V_ACT)]) via hdmi_pack
- o_frame_start  out  1  one-cycle pulse with the first packed cycle of each frame
- o_underflow  out  1  sticky: de asserted without valid pixel

Behaviour:
- Counters and totals:
  - H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP; V_TOTAL likewise.
  - h_cnt runs 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
- Line and frame layout:
  - Horizontal order: sync [0,H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT), front porch.
  - Vertical order follows the same pattern in lines.
- Timing signals:
  - hsync = HS_POL while h in sync region, else ~HS_POL.
  - vsync = VS_POL while v in sync region, else ~VS_POL.
  - de = h active AND v active. href is identical to de.
  - x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP) when de; otherwise 0.
- Handshake and pipeline:
  - o_ready = en_run AND (current counters in active region).
  - A pixel is consumed on i_valid & o_ready.
  - Output stage is registered: 1-cycle latency from counter position to o_pack. Timing fields and the accepted pixel stay aligned.
- Underflow:
  - o_ready & !i_valid: output pixel is 0x000000 and o_underflow sets.
  - No pixel is consumed; the counters still advance, so timing never stalls.
  - o_underflow clears only on reset.
- i_valid while o_ready=0: ignored, not consumed.
- Run control states:
  - IDLE: counters held at 0; outputs at blank level (syncs inactive, de=0, rgb=0, x=y=0); o_ready=0.
  - IDLE->RUN when en=1; first packed cycle follows one cycle later with h=0, v=0.
  - RUN->STOPPING when en=0 mid-frame. STOPPING continues normally until v_cnt/h_cnt wrap to 0,0, then enters IDLE.
  - en=1 again while STOPPING returns to RUN with no gap.
  - en toggling within RUN has no effect on the counters.
- o_frame_start: 1 in the output cycle corresponding to h=0, v=0. The vsync active edge coincides with it.
- Reset (rstn=0 at posedge): state IDLE, counters 0, o_underflow=0, o_frame_start=0, o_ready=0, o_pack at blank level.
  - Reset mid-frame aborts the frame immediately.

Optional Feature:
- Macro: VTP_TEST_PATTERN_EN.
- Defined: underflow pixels are replaced by 8 vertical colour bars chosen by x[top 3 bits of H_ACT range]. Bar order: white, yellow, cyan, green, magenta, red, blue, black. o_underflow still sets.
- Undefined: underflow pixels are black.

Test Plan:
- Config for all scenarios: H_ACT=8, V_ACT=4, H_SYNC=H_BP=H_FP=2, V_SYNC=V_BP=V_FP=1, giving H_TOTAL=14 and V_TOTAL=7.
- Reset, en=1, i_valid=1 constant -> o_frame_start every 98 clocks; hsync high 2 of 14 clocks; vsync high 14 clocks per frame; de count 32 per frame.
- Feed incrementing pixels 0x000001.. -> first de cycle carries x=0, y=0, rgb=0x000001; last carries x=7, y=3, rgb=0x000020; o_underflow=0.
- Drop i_valid for one active cycle at x=3, y=1 -> that pixel black; next pixel carries the undropped value; o_underflow=1 and stays 1; frame length is still 98.
- Deassert en at v_cnt=3 -> frame completes through h=13, v=6, then IDLE with o_ready=0. Re-assert en -> frame_start one cycle later.
- rstn=0 mid-active-line -> next cycle de=0, syncs inactive, o_underflow=0. Hold en=1 and release rstn -> new frame starts from h=0, v=0.
- With VTP_TEST_PATTERN_EN defined, i_valid=0 for a whole frame -> line rgb sequence FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
